// File: rtl/burst_rx_ctrl.sv
// Serial burst sequencer: finds the burst start bit, samples each bit at mid-bit and
// issues one shift_en pulse per bit to the 55-bit collector. Start, stop and parity are checked per frame.
module burst_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FRAME_BITS   = 11,
  parameter int N_FRAMES     = 5,
  parameter int PARITY_ODD   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  output logic                shift_en,
  output logic                ser_bit,
  output logic                active,
  output logic                burst_done,
  output logic [2:0]          frame_idx,
  output logic [N_FRAMES-1:0] frame_err,
  output logic [N_FRAMES-1:0] parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(FRAME_BITS*N_FRAMES+1);
  localparam int PW = $clog2(FRAME_BITS);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT/2-1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT-1);
  localparam logic [BW-1:0] LAST_M1  = BW'(FRAME_BITS*N_FRAMES-1);
  localparam logic [PW-1:0] STOP_POS = PW'(FRAME_BITS-1);
  localparam logic [2:0]    LAST_FR  = 3'(N_FRAMES-1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RECV  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic                r_rx_m, r_rx_s;
  logic [1:0]          r_state;
  logic [CW-1:0]       r_clk_cnt;
  logic [BW-1:0]       r_bit_cnt;
  logic [PW-1:0]       r_pos;
  logic                r_xor;
  logic                r_shift_en, r_ser_bit, r_active, r_burst_done;
  logic [2:0]          r_frame_idx;
  logic [N_FRAMES-1:0] r_frame_err, r_parity_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_rx_m <= rx;
      r_rx_s <= r_rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_clk_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_pos        <= '0;
      r_xor        <= 1'b0;
      r_shift_en   <= 1'b0;
      r_ser_bit    <= 1'b0;
      r_active     <= 1'b0;
      r_burst_done <= 1'b0;
      r_frame_idx  <= '0;
      r_frame_err  <= '0;
      r_parity_err <= '0;
    end else begin
      r_shift_en   <= 1'b0;
      r_burst_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state      <= S_START;
            r_clk_cnt    <= '0;
            r_active     <= 1'b1;
            r_frame_err  <= '0;
            r_parity_err <= '0;
          end
        end
        S_START: begin
          if (r_clk_cnt == HALF_M1) begin
            r_clk_cnt <= '0;
            if (!r_rx_s) begin
              r_shift_en  <= 1'b1;
              r_ser_bit   <= 1'b0;
              r_bit_cnt   <= BW'(1);
              r_pos       <= PW'(1);
              r_frame_idx <= '0;
              r_xor       <= 1'b0;
              r_state     <= S_RECV;
            end else begin
              r_active <= 1'b0;
              r_state  <= S_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_RECV: begin
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt  <= '0;
            r_shift_en <= 1'b1;
            r_ser_bit  <= r_rx_s;
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            // r_pos tracks bit_cnt mod FRAME_BITS without a divider
            if (r_pos == '0) begin
              if (r_rx_s) r_frame_err[r_frame_idx] <= 1'b1;
              r_xor <= 1'b0;
              r_pos <= PW'(1);
            end else if (r_pos == STOP_POS) begin
              if (!r_rx_s) r_frame_err[r_frame_idx] <= 1'b1;
              if (r_xor != 1'(PARITY_ODD)) r_parity_err[r_frame_idx] <= 1'b1;
              if (r_frame_idx != LAST_FR) r_frame_idx <= r_frame_idx + 1'b1;
              r_pos <= '0;
            end else begin
              r_xor <= r_xor ^ r_rx_s;
              r_pos <= r_pos + 1'b1;
            end
            if (r_bit_cnt == LAST_M1) r_state <= S_DONE;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_burst_done <= 1'b1;
          r_active     <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign shift_en   = r_shift_en;
  assign ser_bit    = r_ser_bit;
  assign active     = r_active;
  assign burst_done = r_burst_done;
  assign frame_idx  = r_frame_idx;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;

endmodule
